vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
- Sequences the VGA pixel datapath by generating horizontal/vertical timing (hsync, vsync, active window) from free-running pixel counters.
- Pulls pixel words from the upstream source with a valid/ready handshake only inside the active window; drives registered RGB and sync to the DAC/pins.
- Sits between the frame/line buffer (producer of data_in) and the VGA output pads.

Parameters:
- DATA_WIDTH, 12, pixel word width (RGB 4:4:4).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).

Ports:
- clk  input  1  pixel clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run request; sampled per frame boundary.
- data_in  input  DATA_WIDTH  pixel word from upstream.
- data_valid  input  1  data_in holds a valid pixel.
- data_ready  output  1  controller consumes data_in this cycle.
- rgb_out  output  DATA_WIDTH  registered pixel to DAC.
- hsync  output  1  active-low horizontal sync.
- vsync  output  1  active-low vertical sync.
- active  output  1  rgb_out is in the visible window.
- frame_start  output  1  one-cycle pulse coincident with pixel (0,0) on outputs.
- underflow  output  1  one-cycle pulse: visible pixel requested but data_valid low.
- h_cnt  output  clog2(H_TOTAL)  current horizontal count (pre-register).
- v_cnt  output  clog2(V_TOTAL)  current vertical count (pre-register).

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, FP, sync, BP.
- Reset (rst_n low, async): state IDLE, h_cnt=v_cnt=0, rgb_out=0, hsync=vsync=1, active=0, frame_start=0, underflow=0. data_ready=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0, outputs at reset values. en=1 -> RUN next cycle; first RUN cycle has h_cnt=v_cnt=0.
  - RUN: h_cnt increments each cycle; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps at V_TOTAL-1. en=0 in RUN -> DRAIN.
  - DRAIN: identical to RUN but at the last count (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) -> IDLE if en=0, back to RUN if en=1. Frames are never truncated.
  - At the end of a frame in RUN with en=1, continue to the next frame without a gap.
- Visible window: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, in RUN or DRAIN.
- data_ready = visible window (combinational from counters/state). The handshake completes when data_ready and data_valid are both high. No consumption outside the window; data_valid is ignored there.
- Output latency: exactly 1 cycle. rgb_out, hsync, vsync, active, frame_start and underflow are registered from the counter values of the previous cycle, so they are mutually aligned.
  - rgb_out = data_in if window and data_valid; 0 otherwise (blanking forced to 0).
  - hsync low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule on v_cnt (full lines).
  - frame_start high when the counter value was (0,0) in RUN.
  - underflow high when window=1 and data_valid=0. The pixel is output as 0; the timing does not stall.
- The controller never stalls the counters; upstream must keep pace.
- Reset asserted mid-frame: immediate return to reset values; no partial frame resumes.

Test Plan:
- Small params (H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1), en=1, data_valid=1, data_in=incrementing from 0x001 -> rgb_out 0x001..0x00C over the 12 visible cycles; one cycle after h_cnt=5 hsync low for 2 cycles; vsync low during line v_cnt=4; frame period 48 cycles; frame_start every 48 cycles.
- Same setup, data_valid=0 at the 3rd visible pixel of line 1 -> rgb_out=0 and underflow=1 for exactly that output cycle; subsequent pixels resume; timing unchanged.
- data_valid=1 throughout blanking -> data_ready=0 and rgb_out=0 in all non-visible cycles; no words are consumed (count handshakes = 12 per frame).
- en dropped at v_cnt=1 -> frame completes through (7,5); IDLE on the next cycle with hsync=vsync=1; re-raise en -> next frame_start 2 cycles later.
- rst_n pulsed low mid-line (h_cnt=2, v_cnt=1) -> all outputs go to reset values asynchronously; after release with en=1, frame_start occurs at the expected cycle offset from (0,0).
- Default 640x480 params, 2 frames -> 800x525 = 420000 cycles per frame; hsync low 96 cycles per line, vsync low 1600 cycles per frame.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: free-running h/v counters frame a valid/ready pull from
// upstream and drive registered RGB, syncs and status pulses to the output pads.
module vga_timing_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    en,
    input  logic [DATA_WIDTH-1:0]                                   data_in,
    input  logic                                                    data_valid,
    output logic                                                    data_ready,
    output logic [DATA_WIDTH-1:0]                                   rgb_out,
    output logic                                                    hsync,
    output logic                                                    vsync,
    output logic                                                    active,
    output logic                                                    frame_start,
    output logic                                                    underflow,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]            h_cnt,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]            v_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;

    logic running, h_last, v_last, window, in_hsync, in_vsync, at_origin;

    assign running    = (state != IDLE);
    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
    assign window     = running && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign in_hsync   = running && (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign in_vsync   = running && (v_cnt >= V_SS) && (v_cnt < V_SE);
    assign data_ready = window;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            rgb_out     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            // Output stage: everything derives from this cycle's counters, so all
            // pad signals share the same one-cycle latency.
            rgb_out     <= (window && data_valid) ? data_in : '0;
            hsync       <= !in_hsync;
            vsync       <= !in_vsync;
            active      <= window;
            frame_start <= (state == RUN) && at_origin;
            underflow   <= window && !data_valid;

            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (en) state <= RUN;
                end
                RUN, DRAIN: begin
                    if (h_last) begin
                        h_cnt <= '0;
                        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
                    end else begin
                        h_cnt <= h_cnt + HW'(1);
                    end
                    // en only takes effect at a frame boundary; frames always finish.
                    if (h_last && v_last) state <= en ? RUN : IDLE;
                    else if (state == RUN && !en) state <= DRAIN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on an 8x6 total / 4x3 visible raster.
module tb_vga_timing_ctrl;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_ready, hsync, vsync, active, frame_start, underflow;
    logic [DW-1:0] rgb_out;
    logic [2:0]    h_cnt, v_cnt;

    vga_timing_ctrl #(
        .DATA_WIDTH(DW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .rgb_out(rgb_out),
        .hsync(hsync), .vsync(vsync), .active(active), .frame_start(frame_start),
        .underflow(underflow), .h_cnt(h_cnt), .v_cnt(v_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            fr;
        int            c;
        logic          ready;
        logic [2:0]    h;
        logic [2:0]    v;
        logic [DW-1:0] rgb;
        logic          hs, vs, act, fs, uf;
    } exp_t;

    exp_t          sbq[$];
    int            n_vec = 0;
    int            n_bad = 0;
    int            hk = 0, hsl = 0, vsl = 0, fsn = 0, ufn = 0;
    logic [DW-1:0] word = 12'h001;

    // Expected values from raster position c (0..47) within a frame, c<0 = idle/reset.
    task automatic drv(input logic rn, input logic e, input logic dv, input int fr, input int c);
        exp_t x;
        int   h, v;
        logic win;
        rst_n = rn; en = e; data_valid = dv; data_in = word;
        h = (c < 0) ? 0 : c % 8;
        v = (c < 0) ? 0 : c / 8;
        win = (c >= 0) && (h < 4) && (v < 3);
        x.fr = fr; x.c = c;
        x.ready = win; x.h = 3'(h); x.v = 3'(v);
        x.rgb = (win && dv) ? word : 12'h000;
        x.act = win;
        x.uf  = win && !dv;
        x.hs  = !((c >= 0) && (h == 5 || h == 6));
        x.vs  = !((c >= 0) && (v == 4));
        x.fs  = (c == 0);
        sbq.push_back(x);
        if (win && dv) word = word + 12'h001;
    endtask

    task automatic tick(input logic rn, input logic e, input logic dv, input int fr, input int c);
        @(negedge clk);
        drv(rn, e, dv, fr, c);
    endtask

    task automatic clear_counts();
        hk = 0; hsl = 0; vsl = 0; fsn = 0; ufn = 0;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_counts(input int fr, input int ehk, input int ehsl, input int evsl,
                                input int efsn, input int eufn);
        chk($sformatf("f%0d_handshakes", fr), hk, ehk);
        chk($sformatf("f%0d_hsync_low", fr), hsl, ehsl);
        chk($sformatf("f%0d_vsync_low", fr), vsl, evsl);
        chk($sformatf("f%0d_frame_starts", fr), fsn, efsn);
        chk($sformatf("f%0d_underflows", fr), ufn, eufn);
        clear_counts();
    endtask

    // Monitor: pre-edge sample of combinational/counter outputs, post-edge of registers.
    initial begin
        logic       p_rdy, p_hk;
        logic [2:0] p_h, p_v;
        exp_t       x;
        forever begin
            @(negedge clk); #2;
            p_rdy = data_ready; p_h = h_cnt; p_v = v_cnt;
            p_hk  = data_ready && data_valid;
            @(posedge clk); #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                n_vec++;
                if (p_rdy !== x.ready || p_h !== x.h || p_v !== x.v || rgb_out !== x.rgb ||
                    hsync !== x.hs || vsync !== x.vs || active !== x.act ||
                    frame_start !== x.fs || underflow !== x.uf) begin
                    n_bad++;
                    $display("FAIL vec f%0d_c%0d: got rdy=%b h=%0d v=%0d rgb=%h hs=%b vs=%b act=%b fs=%b uf=%b, want rdy=%b h=%0d v=%0d rgb=%h hs=%b vs=%b act=%b fs=%b uf=%b",
                             x.fr, x.c, p_rdy, p_h, p_v, rgb_out, hsync, vsync, active,
                             frame_start, underflow, x.ready, x.h, x.v, x.rgb, x.hs, x.vs,
                             x.act, x.fs, x.uf);
                end
                hk  += int'(p_hk);
                hsl += int'(!hsync);
                vsl += int'(!vsync);
                fsn += int'(frame_start);
                ufn += int'(underflow);
            end
        end
    end

    initial begin
        repeat (2) tick(1'b0, 1'b0, 1'b0, 0, -1);
        repeat (2) tick(1'b1, 1'b0, 1'b1, 0, -1);
        tick(1'b1, 1'b1, 1'b1, 0, -1);

        // Frame 1: valid held high everywhere, including blanking.
        @(negedge clk); clear_counts(); drv(1'b1, 1'b1, 1'b1, 1, 0);
        for (int c = 1; c < 48; c++) tick(1'b1, 1'b1, 1'b1, 1, c);

        // Frame 2: starve the 3rd visible pixel of line 1.
        @(negedge clk); check_counts(1, 12, 12, 8, 1, 0); drv(1'b1, 1'b1, 1'b1, 2, 0);
        for (int c = 1; c < 48; c++) tick(1'b1, 1'b1, (c != 10), 2, c);

        // Frame 3: en dropped at line 1, frame must still complete.
        @(negedge clk); check_counts(2, 11, 12, 8, 1, 1); drv(1'b1, 1'b1, 1'b1, 3, 0);
        for (int c = 1; c < 48; c++) tick(1'b1, (c < 8), 1'b1, 3, c);

        @(negedge clk); check_counts(3, 12, 12, 8, 1, 0); drv(1'b1, 1'b0, 1'b1, 3, -1);
        repeat (2) tick(1'b1, 1'b0, 1'b1, 3, -1);
        tick(1'b1, 1'b1, 1'b1, 4, -1);

        // Frame 4: async reset hits at (2,1).
        for (int c = 0; c < 10; c++) tick(1'b1, 1'b1, 1'b1, 4, c);
        repeat (2) tick(1'b0, 1'b1, 1'b1, 4, -1);
        tick(1'b1, 1'b1, 1'b1, 5, -1);

        @(negedge clk); clear_counts(); drv(1'b1, 1'b1, 1'b1, 5, 0);
        for (int c = 1; c < 48; c++) tick(1'b1, 1'b1, 1'b1, 5, c);
        @(negedge clk); check_counts(5, 12, 12, 8, 1, 0);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
